// File: rtl/wave_seq_ctrl.sv
// ---------------------------------------------------------------------------
// wave_seq_ctrl
//   Command-driven sequencer for the waveform datapath. One command (shape,
//   lo/hi limits, step, period count) is taken over a valid/ready handshake.
//   The block then steps `wave` between the limits, pulses `period_tick` at
//   the end of every period and `done` when the command ends.
//
//   Shapes: 00 triangle, 01 saw-up, 10 square, 11 reserved (rejected).
//   For triangle/saw, the first sample after accept is lo. For square, the
//   first sample is hi, so the high half-period is exactly `step` samples.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   cmd_valid/_ready  command handshake (ready only in IDLE)
//   cmd_shape, cmd_lo, cmd_hi, cmd_step, cmd_periods  command fields
//                  (cmd_periods == 0 runs until abort)
//   abort          end the running command, wave frozen at its current value
//   pause          (only with WAVE_SEQ_PAUSE_EN) freeze state, wave, counters
//   wave           waveform sample
//   busy           any state other than IDLE
//   period_tick    1-cycle pulse per completed period
//   done           1-cycle pulse when a command ends
//   cmd_err        1-cycle pulse when a command is rejected
//
// Configuration macro: WAVE_SEQ_PAUSE_EN adds the `pause` input.
// ---------------------------------------------------------------------------
module wave_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_shape,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [CNT_W-1:0] cmd_periods,
  input  logic             abort,
`ifdef WAVE_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] wave,
  output logic             busy,
  output logic             period_tick,
  output logic             done,
  output logic             cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_UP, S_DOWN, S_WRAP, S_SQ_HI, S_SQ_LO, S_FINISH
  } state_t;

  localparam logic [1:0] SHAPE_SAW = 2'b01;
  localparam logic [1:0] SHAPE_SQ  = 2'b10;
  localparam logic [1:0] SHAPE_RSV = 2'b11;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   wave_q, wave_n;
  logic [WIDTH-1:0]   lo_q, hi_q, step_q;
  logic               saw_q;
  logic [CNT_W-1:0]   periods_q;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [WIDTH-1:0]   sq_q, sq_n;      // clocks spent in current square half
  logic               tick_q, tick_n;
  logic               err_q, err_n;
  logic               latch_cmd;
  logic               period_end;
  logic               hold;

  // Limit arithmetic is one bit wider so lo+step / wave+step never wrap.
  logic [WIDTH:0]     up_sum, dn_thr;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_period;
  logic               cmd_bad;

`ifdef WAVE_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign up_sum      = {1'b0, wave_q} + {1'b0, step_q};
  assign dn_thr      = {1'b0, lo_q} + {1'b0, step_q};
  // Saturating period counter: continuous mode keeps ticking without wrap.
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign last_period = (periods_q != '0) && (cnt_inc == periods_q);
  assign cmd_bad     = (cmd_lo >= cmd_hi) || (cmd_step == '0) ||
                       (cmd_shape == SHAPE_RSV);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can infer a latch.
    state_n    = state_q;
    wave_n     = wave_q;
    cnt_n      = cnt_q;
    sq_n       = sq_q;
    tick_n     = 1'b0;
    err_n      = 1'b0;
    latch_cmd  = 1'b0;
    period_end = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_n = 1'b1;
          end else begin
            latch_cmd = 1'b1;
            cnt_n     = '0;
            sq_n      = {{(WIDTH-1){1'b0}}, 1'b1};
            if (cmd_shape == SHAPE_SQ) begin
              state_n = S_SQ_HI;
              wave_n  = cmd_hi;
            end else begin
              state_n = S_UP;
              wave_n  = cmd_lo;
            end
          end
        end
      end

      S_FINISH: state_n = S_IDLE;

      default: begin
        // Abort wins over pause and over a same-cycle period end.
        if (abort) begin
          state_n = S_FINISH;
        end else if (!hold) begin
          unique case (state_q)
            S_UP: begin
              if (up_sum >= {1'b0, hi_q}) begin
                wave_n  = hi_q;
                state_n = saw_q ? S_WRAP : S_DOWN;
              end else begin
                wave_n = up_sum[WIDTH-1:0];
              end
            end
            S_DOWN: begin
              if ({1'b0, wave_q} <= dn_thr) begin
                wave_n     = lo_q;
                state_n    = S_UP;
                period_end = 1'b1;
              end else begin
                wave_n = wave_q - step_q;
              end
            end
            S_WRAP: begin
              wave_n     = lo_q;
              state_n    = S_UP;
              period_end = 1'b1;
            end
            S_SQ_HI: begin
              if (sq_q == step_q) begin
                wave_n  = lo_q;
                state_n = S_SQ_LO;
                sq_n    = {{(WIDTH-1){1'b0}}, 1'b1};
              end else begin
                sq_n = sq_q + 1'b1;
              end
            end
            S_SQ_LO: begin
              if (sq_q == step_q) begin
                wave_n     = hi_q;
                state_n    = S_SQ_HI;
                sq_n       = {{(WIDTH-1){1'b0}}, 1'b1};
                period_end = 1'b1;
              end else begin
                sq_n = sq_q + 1'b1;
              end
            end
            default: state_n = S_IDLE;
          endcase

          if (period_end) begin
            tick_n = 1'b1;
            cnt_n  = cnt_inc;
            if (last_period) begin
              state_n = S_FINISH;
              wave_n  = lo_q;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wave_q    <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      step_q    <= '0;
      saw_q     <= 1'b0;
      periods_q <= '0;
      cnt_q     <= '0;
      sq_q      <= '0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_n;
      wave_q  <= wave_n;
      cnt_q   <= cnt_n;
      sq_q    <= sq_n;
      tick_q  <= tick_n;
      err_q   <= err_n;
      if (latch_cmd) begin
        lo_q      <= cmd_lo;
        hi_q      <= cmd_hi;
        step_q    <= cmd_step;
        saw_q     <= (cmd_shape == SHAPE_SAW);
        periods_q <= cmd_periods;
      end
    end
  end

  assign wave        = wave_q;
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign period_tick = tick_q;
  assign done        = (state_q == S_FINISH);
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wave_seq_ctrl
//   Directed stimulus with a scoreboard: expected {wave, tick, done} samples
//   are queued before each command; a monitor pops one entry per busy cycle.
// ---------------------------------------------------------------------------
module tb_wave_seq_ctrl;

  localparam int WIDTH = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_shape;
  logic [WIDTH-1:0] cmd_lo, cmd_hi, cmd_step;
  logic [CNT_W-1:0] cmd_periods;
  logic             abort;
  logic             pause;
  logic [WIDTH-1:0] wave;
  logic             busy, period_tick, done, cmd_err;

  wave_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_shape   (cmd_shape),
    .cmd_lo      (cmd_lo),
    .cmd_hi      (cmd_hi),
    .cmd_step    (cmd_step),
    .cmd_periods (cmd_periods),
    .abort       (abort),
`ifdef WAVE_SEQ_PAUSE_EN
    .pause       (pause),
`endif
    .wave        (wave),
    .busy        (busy),
    .period_tick (period_tick),
    .done        (done),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] wave;
    logic             tick;
    logic             done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void push(input int w, input bit t, input bit d);
    exp_t e;
    e.wave = w[WIDTH-1:0];
    e.tick = t;
    e.done = d;
    sb.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per busy cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_busy: got wave=%0d tick=%0b done=%0b expected no activity",
                     wave, period_tick, done);
          end else begin
            e = sb.pop_front();
            if (wave !== e.wave || period_tick !== e.tick || done !== e.done) begin
              n_fail++;
              $display("FAIL sample: got wave=%0d tick=%0b done=%0b expected wave=%0d tick=%0b done=%0b",
                       wave, period_tick, done, e.wave, e.tick, e.done);
            end
          end
        end else if (period_tick || done) begin
          n_cmp++;
          n_fail++;
          $display("FAIL idle_pulse: got tick=%0b done=%0b expected 0 0", period_tick, done);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Present a command for one edge; returns #1 after that edge.
  task automatic send(input logic [1:0] shape, input int lo, input int hi,
                      input int step, input int per);
    @(posedge clk); #1;
    cmd_shape   = shape;
    cmd_lo      = lo[WIDTH-1:0];
    cmd_hi      = hi[WIDTH-1:0];
    cmd_step    = step[WIDTH-1:0];
    cmd_periods = per[CNT_W-1:0];
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check({name, "_idle"}, busy, 0);
    @(posedge clk); #1;
    check({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    int tri_w[13] = '{4, 7, 10, 12, 9, 6, 4, 7, 10, 12, 9, 6, 4};
    int saw_w[6]  = '{0, 8, 16, 24, 31, 0};
    int sq_w[15]  = '{20, 20, 20, 2, 2, 2, 20, 20, 20, 2, 2, 2, 20, 20, 20};

    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; pause = 1'b0;
    cmd_shape = '0; cmd_lo = '0; cmd_hi = '0; cmd_step = '0; cmd_periods = '0;

    // 1. Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_wave", wave, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", {period_tick, done, cmd_err}, 0);

    // 2. Triangle, two periods; extra commands while busy must be ignored
    for (int i = 0; i < 13; i++) push(tri_w[i], (i == 6) || (i == 12), i == 12);
    send(2'b00, 4, 12, 3, 2);
    check("tri_ready_low", cmd_ready, 0);
    check("tri_busy", busy, 1);
    cmd_shape = 2'b01; cmd_lo = 0; cmd_hi = 31; cmd_step = 1; cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle("tri");
    check("tri_end_wave", wave, 4);
    check("tri_ready_back", cmd_ready, 1);

    // 3. Saw to the top of range, no wrap past 31
    for (int i = 0; i < 6; i++) push(saw_w[i], i == 5, i == 5);
    send(2'b01, 0, 31, 8, 1);
    wait_idle("saw");

    // 5. Rejected commands
    send(2'b00, 9, 9, 1, 1);
    check("rej_eq_err", cmd_err, 1);
    check("rej_eq_busy", busy, 0);
    check("rej_eq_wave", wave, 0);
    @(posedge clk); #1;
    check("rej_err_pulse", cmd_err, 0);
    send(2'b00, 2, 9, 0, 1);
    check("rej_step_err", cmd_err, 1);
    check("rej_step_ready", cmd_ready, 1);
    send(2'b11, 2, 9, 1, 1);
    check("rej_shape_err", cmd_err, 1);
    check("rej_shape_busy", busy, 0);

    // 4. Continuous square, abort mid SQ_HI: wave frozen at hi, no tick
    for (int i = 0; i < 15; i++) push(sq_w[i], (i == 6) || (i == 12), i == 14);
    send(2'b10, 2, 20, 3, 0);
    repeat (13) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_idle("sq");
    check("sq_abort_wave", wave, 20);

    // Abort on a period-end edge (saw WRAP): no tick, wave stays at hi
    push(0, 0, 0); push(5, 0, 0); push(0, 1, 0); push(5, 0, 0); push(5, 0, 1);
    send(2'b01, 0, 5, 5, 0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_idle("wrap_abort");
    check("wrap_abort_wave", wave, 5);

    // Abort in IDLE has no effect
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("idle_abort_busy", busy, 0);

    // 6. Async reset mid-DOWN (wave=9), then a fresh command
    push(4, 0, 0); push(7, 0, 0); push(10, 0, 0); push(12, 0, 0); push(9, 0, 0);
    send(2'b00, 4, 12, 3, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_wave", wave, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ready", cmd_ready, 1);
    check("arst_drained", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) push(saw_w[i], i == 5, i == 5);
    send(2'b01, 0, 31, 8, 1);
    wait_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
